// File: rtl/cs220_seq_pkg.sv
// Shared types and constants for the serializer and the 1010 sequence detector.
package cs220_seq_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   localparam int DEFAULT_WIDTH = 8;

   // Pattern the downstream detector looks for; its bench shares this constant.
   localparam logic [3:0] SEQ_PATTERN = 4'b1010;

endpackage

// File: rtl/bit_serializer_if.sv
// Parallel word load handshake between a word producer and the bit serializer.
interface bit_serializer_if #(
   parameter int WIDTH = cs220_seq_pkg::DEFAULT_WIDTH
);

   logic [WIDTH-1:0] data_in;
   logic             load_valid;
   logic             load_ready;

   modport master (
      output data_in,
      output load_valid,
      input  load_ready
   );

   modport slave (
      input  data_in,
      input  load_valid,
      output load_ready
   );

endinterface

// File: rtl/bit_serializer.sv
// Parallel-to-serial converter with a one-word holding buffer so consecutive
// words stream out with no idle bit between them.
//
// state | meaning
// IDLE  | nothing shifting, serial outputs quiet
// SHIFT | word in shreg, bit cnt presented on serial_out
module bit_serializer
   import cs220_seq_pkg::*;
#(
   parameter int WIDTH     = DEFAULT_WIDTH,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic            clk,
   input  logic            reset,
   bit_serializer_if.slave loadBus,
   output logic            serial_out,
   output logic            bit_valid,
   output logic            word_done
);

   localparam int            CW   = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_t           state;
   state_t           stateNext;
   logic [WIDTH-1:0] shreg;
   logic [WIDTH-1:0] shregNext;
   logic [WIDTH-1:0] hold;
   logic [WIDTH-1:0] holdNext;
   logic [CW-1:0]    cnt;
   logic [CW-1:0]    cntNext;
   logic             hold_full;
   logic             holdFullNext;

   logic             accept;
   logic             lastBit;
   logic             direct;
   logic             curBit;
   logic [WIDTH-1:0] shifted;

   // Ready depends only on reset and the hold flag, never on load_valid.
   assign loadBus.load_ready = reset && !hold_full;
   assign accept             = loadBus.load_valid && loadBus.load_ready;
   assign lastBit            = (state == SHIFT) && (cnt == LAST);
   assign direct             = accept && ((state == IDLE) || lastBit);

   // The presented bit always sits at the outgoing end of shreg.
   assign curBit  = MSB_FIRST ? shreg[WIDTH-1] : shreg[0];
   assign shifted = MSB_FIRST ? {shreg[WIDTH-2:0], 1'b0} : {1'b0, shreg[WIDTH-1:1]};

   assign serial_out = (state == SHIFT) && curBit;
   assign bit_valid  = (state == SHIFT);
   assign word_done  = lastBit;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         cnt       <= '0;
         shreg     <= '0;
         hold      <= '0;
         hold_full <= 1'b0;
      end else begin
         state     <= stateNext;
         cnt       <= cntNext;
         shreg     <= shregNext;
         hold      <= holdNext;
         hold_full <= holdFullNext;
      end
   end

   always_comb begin
      stateNext    = state;
      cntNext      = cnt;
      shregNext    = shreg;
      holdNext     = hold;
      holdFullNext = hold_full;

      case (state)
         IDLE: begin
            if (direct) begin
               shregNext = loadBus.data_in;
               cntNext   = '0;
               stateNext = SHIFT;
            end
         end
         SHIFT: begin
            if (!lastBit) begin
               cntNext   = cnt + CW'(1);
               shregNext = shifted;
            end else if (hold_full) begin
               shregNext    = hold;
               holdFullNext = 1'b0;
               cntNext      = '0;
            end else if (direct) begin
               shregNext = loadBus.data_in;
               cntNext   = '0;
            end else begin
               cntNext   = '0;
               stateNext = IDLE;
            end
         end
         default: stateNext = IDLE;
      endcase

      // A word that cannot go straight into shreg waits in hold.
      if (accept && !direct) begin
         holdNext     = loadBus.data_in;
         holdFullNext = 1'b1;
      end
   end

endmodule
